// File: rtl/sum_frame_source.sv
// Frame source for a downstream 128-byte summer: emits a start flag plus 128
// constant or LFSR bytes, keeps its own running sum and checks the summer's answer.
module sum_frame_source (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        const_mode,
  input  logic [7:0]  seed,
  input  logic [16:0] sum_in,
  input  logic        sum_enable_in,
  output logic [7:0]  output_data,
  output logic        data_start,
  output logic        busy,
  output logic [16:0] expected_sum,
  output logic        done,
  output logic        pass,
  output logic        timeout
);

  // state | meaning
  // IDLE  | waiting for start; results of the last frame held
  // START | one cycle with data_start high
  // SEND  | 128 data cycles, cnt_q numbers them 0..127
  // WAIT  | waiting for the summer's strobe, tmo_q counts 0..47
  typedef enum logic [1:0] {IDLE, START, SEND, WAIT} state_t;

  localparam logic [6:0] LAST_BYTE = 7'd127;
  localparam logic [5:0] LAST_WAIT = 6'd47;

  state_t      state_q, state_d;
  logic        mode_q, mode_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [5:0]  tmo_q, tmo_d;
  logic [7:0]  data_q, data_d;
  logic        ds_q, ds_d;
  logic        busy_q, busy_d;
  logic [16:0] sum_q, sum_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  lfsr_adv;

  // Constant mode simply holds the seed in the LFSR register.
  assign lfsr_adv = mode_q ? lfsr_q
                           : {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    lfsr_d    = lfsr_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    data_d    = data_q;
    ds_d      = 1'b0;
    sum_d     = sum_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d    = const_mode;
          lfsr_d    = (!const_mode && seed == 8'h00) ? 8'h01 : seed;
          cnt_d     = '0;
          tmo_d     = '0;
          data_d    = 8'h00;
          ds_d      = 1'b1;
          sum_d     = '0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        data_d  = lfsr_q;
        lfsr_d  = lfsr_adv;
        cnt_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        sum_d = sum_q + {9'd0, data_q};
        if (cnt_q == LAST_BYTE) begin
          data_d  = 8'h00;
          tmo_d   = '0;
          state_d = WAIT;
        end else begin
          cnt_d  = cnt_q + 7'd1;
          data_d = lfsr_q;
          lfsr_d = lfsr_adv;
        end
      end
      WAIT: begin
        // A strobe on the final count still wins over the timeout.
        if (sum_enable_in) begin
          pass_d  = (sum_in == sum_q);
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (tmo_q == LAST_WAIT) begin
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      lfsr_q    <= 8'h01;
      cnt_q     <= '0;
      tmo_q     <= '0;
      data_q    <= 8'h00;
      ds_q      <= 1'b0;
      busy_q    <= 1'b0;
      sum_q     <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      lfsr_q    <= lfsr_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      data_q    <= data_d;
      ds_q      <= ds_d;
      busy_q    <= busy_d;
      sum_q     <= sum_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
    end
  end

  assign output_data  = data_q;
  assign data_start   = ds_q;
  assign busy         = busy_q;
  assign expected_sum = sum_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_sum_frame_source.sv
// Directed bench for sum_frame_source: a frame-level model predicts every output
// cycle by cycle; literal checks pin the model and key results.
module tb_sum_frame_source;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic        const_mode = 1'b0;
  logic [7:0]  seed = 8'h00;
  logic [16:0] sum_in = '0;
  logic        sum_enable_in = 1'b0;
  logic [7:0]  output_data;
  logic        data_start;
  logic        busy;
  logic [16:0] expected_sum;
  logic        done;
  logic        pass;
  logic        timeout;

  sum_frame_source dut (
    .CLK(CLK), .RST(RST), .start(start), .const_mode(const_mode), .seed(seed),
    .sum_in(sum_in), .sum_enable_in(sum_enable_in), .output_data(output_data),
    .data_start(data_start), .busy(busy), .expected_sum(expected_sum),
    .done(done), .pass(pass), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0]  data;
    logic        ds;
    logic        busy;
    logic [16:0] esum;
    logic        done;
    logic        pass;
    logic        tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] mb [128];
  int   mtot;
  logic [16:0] last_esum = '0;
  logic        last_pass = 1'b0;
  logic        last_tmo  = 1'b0;

  function automatic void chk(input string nm, input logic [16:0] act, input logic [16:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h, t=%0t", nm, act, req, $time);
    end
  endfunction

  // Byte stream of a frame, straight from the seed/mode rules.
  task automatic model_gen(input logic cm, input logic [7:0] sd);
    logic [7:0] l;
    l = (cm || sd != 8'h00) ? sd : 8'h01;
    mtot = 0;
    for (int i = 0; i < 128; i++) begin
      mb[i] = l;
      mtot += int'(l);
      if (!cm) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e = '{data: 8'h00, ds: 1'b0, busy: 1'b0, esum: last_esum, done: 1'b0,
          pass: last_pass, tmo: last_tmo};
    return e;
  endfunction

  initial begin : compare
    exp_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("output_data",  {9'd0, output_data}, {9'd0, e.data});
        chk("data_start",   {16'd0, data_start}, {16'd0, e.ds});
        chk("busy",         {16'd0, busy},       {16'd0, e.busy});
        chk("expected_sum", expected_sum,        e.esum);
        chk("done",         {16'd0, done},       {16'd0, e.done});
        chk("pass",         {16'd0, pass},       {16'd0, e.pass});
        chk("timeout",      {16'd0, timeout},    {16'd0, e.tmo});
      end
    end
  end

  // Called and returns at a negedge of an IDLE cycle. d = WAIT cycle of the
  // strobe (0..47) or -1 for none; sum_in = model sum + delta.
  task automatic frame(input logic cm, input logic [7:0] sd, input int d, input int delta,
                       input logic hold, input logic stray, input logic reassert);
    int   w, dn, part;
    exp_t e;
    model_gen(cm, sd);
    w  = (d >= 0) ? d + 1 : 48;
    dn = 129 + w;
    part = 0;
    for (int c = 0; c <= dn; c++) begin
      e = '{data: 8'h00, ds: 1'b0, busy: 1'b1, esum: 17'(part), done: 1'b0,
            pass: 1'b0, tmo: 1'b0};
      if (c == 0) e.ds = 1'b1;
      else if (c <= 128) begin
        e.data = mb[c-1];
        part += int'(mb[c-1]);
      end else e.esum = 17'(mtot);
      if (c == dn) begin
        e.busy = 1'b0;
        e.done = 1'b1;
        e.pass = (d >= 0) && (delta == 0);
        e.tmo  = (d < 0);
        last_esum = e.esum;
        last_pass = e.pass;
        last_tmo  = e.tmo;
      end
      exp_q.push_back(e);
    end
    start = 1'b1;
    const_mode = cm;
    seed = sd;
    sum_in = 17'(mtot + delta);
    for (int c = 0; c <= dn; c++) begin
      @(negedge CLK);
      start = hold || (reassert && c == 50);
      if (reassert && c == 50) begin
        const_mode = ~cm;
        seed = 8'h5A;
      end
      sum_enable_in = (d >= 0 && c == 129 + d) || (stray && c == 10);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      exp_q.push_back(idle_exp());
      @(negedge CLK);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    logic [16:0] s;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_data", {9'd0, output_data}, 17'd0);
    chk("rst_busy", {16'd0, busy}, 17'd0);
    chk("rst_esum", expected_sum, 17'd0);
    chk("rst_flags", {13'd0, data_start, done, pass, timeout}, 17'd0);
    @(negedge CLK);
    RST = 1'b0;
    idle(2);

    // Constant FF frame, correct sum.
    frame(1'b1, 8'hFF, 5, 0, 1'b0, 1'b0, 1'b0);
    chk("max_esum", expected_sum, 17'h07F80);
    chk("max_pass", {16'd0, pass}, 17'd1);
    chk("max_done", {16'd0, done}, 17'd1);
    idle(2);

    // Constant 01 frame, summer answers 0x81; stray strobe during SEND.
    frame(1'b1, 8'h01, 0, 1, 1'b0, 1'b1, 1'b0);
    chk("mis_esum", expected_sum, 17'h00080);
    chk("mis_pass", {16'd0, pass}, 17'd0);
    chk("mis_tmo", {16'd0, timeout}, 17'd0);
    idle(3);

    // No strobe at all: timeout.
    frame(1'b0, 8'h00, -1, 0, 1'b0, 1'b0, 1'b0);
    chk("to_tmo", {16'd0, timeout}, 17'd1);
    chk("to_pass", {16'd0, pass}, 17'd0);
    chk("lfsr_b0", {9'd0, mb[0]}, 17'h01);
    chk("lfsr_b1", {9'd0, mb[1]}, 17'h02);
    chk("lfsr_b2", {9'd0, mb[2]}, 17'h04);
    chk("lfsr_b3", {9'd0, mb[3]}, 17'h08);
    idle(2);

    // LFSR zero seed, correct sum.
    frame(1'b0, 8'h00, 10, 0, 1'b0, 1'b0, 1'b0);
    chk("lfsr_pass", {16'd0, pass}, 17'd1);
    idle(1);

    // Strobe on the final WAIT count, start held into the next frame.
    frame(1'b0, 8'hA5, 47, 0, 1'b1, 1'b0, 1'b0);
    chk("edge_pass", {16'd0, pass}, 17'd1);
    chk("edge_tmo", {16'd0, timeout}, 17'd0);
    frame(1'b1, 8'h07, 3, 2, 1'b0, 1'b0, 1'b0);
    idle(2);

    // start re-asserted mid-SEND is ignored.
    frame(1'b0, 8'h3C, 20, 0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Mid-SEND reset aborts the frame.
    start = 1'b1;
    const_mode = 1'b0;
    seed = 8'h3C;
    @(negedge CLK);
    start = 1'b0;
    repeat (60) @(negedge CLK);
    chk("pre_rst_busy", {16'd0, busy}, 17'd1);
    RST = 1'b1;
    #1;
    chk("arst_data", {9'd0, output_data}, 17'd0);
    chk("arst_busy", {16'd0, busy}, 17'd0);
    chk("arst_esum", expected_sum, 17'd0);
    chk("arst_flags", {13'd0, data_start, done, pass, timeout}, 17'd0);
    @(negedge CLK);
    RST = 1'b0;
    s = '0;
    repeat (200) begin
      @(negedge CLK);
      s = s | {15'd0, done, busy};
    end
    chk("post_rst_quiet", s, 17'd0);
    last_esum = '0;
    last_pass = 1'b0;
    last_tmo  = 1'b0;
    idle(1);

    // Constant-mode zero seed stays zero.
    frame(1'b1, 8'h00, 2, 0, 1'b0, 1'b0, 1'b0);
    chk("zero_esum", expected_sum, 17'd0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sum_frame_source.md
SUM_FRAME_SOURCE -- requirements
Module: sum_frame_source

Interface
REQ-001 Ports, one clock; reset is asynchronous and active-high (CLK, RST).
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- start  in  1  request one frame; sampled in IDLE only.
- const_mode  in  1  1 = every byte equals seed; 0 = LFSR sequence; sampled with start.
- seed  in  8  LFSR seed or constant byte; sampled with start.
- sum_in  in  17  result from downstream 128-byte summer.
- sum_enable_in  in  1  one-cycle strobe marking sum_in valid.
- output_data  out  8  frame byte to summer.
- data_start  out  1  first-data flag to summer.
- busy  out  1  high in any state other than IDLE.
- expected_sum  out  17  locally accumulated sum of the bytes sent.
- done  out  1  one-cycle completion strobe.
- pass  out  1  compare result; valid from done, held until next start.
- timeout  out  1  no sum_enable_in within window; held until next start.

Function
REQ-002 FSM states: IDLE, START, SEND, WAIT; all outputs registered.
REQ-003 IDLE: start=1 -> capture const_mode and seed; clear expected_sum, pass and timeout; go to START. start is ignored outside IDLE.
REQ-004 Zero-seed rule: in LFSR mode, seed 8'h00 is loaded as 8'h01. In constant mode, 8'h00 is used as-is.
REQ-005 START lasts exactly one cycle: data_start=1, output_data=8'h00; then go to SEND.
REQ-006 SEND lasts exactly 128 consecutive cycles, numbered 0..127 by a 7-bit counter; data_start=0.
REQ-007 First byte: SEND cycle 0 presents the loaded value.
REQ-008 Byte advance: each subsequent cycle presents the next value.
- LFSR next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- Constant mode repeats seed.
REQ-009 expected_sum adds each byte presented (17-bit zero-extended add); the value is final one cycle after SEND cycle 127. Maximum 128*255 = 32640 fits without overflow.
REQ-010 After SEND cycle 127: go to WAIT; output_data returns to 8'h00.
REQ-011 WAIT runs a 6-bit timeout counter, starting at 0.
REQ-012 WAIT, sum_enable_in=1 on or before counter value 47:
- pass = (sum_in == expected_sum);
- done pulses one cycle;
- go to IDLE.
REQ-013 WAIT, counter reaches 47 without sum_enable_in:
- timeout=1, pass=0;
- done pulses one cycle;
- go to IDLE.
REQ-014 sum_enable_in outside WAIT is ignored; it does not affect pass or timeout.
REQ-015 When sum_enable_in and the counter's last value coincide, the strobe wins: compare is performed and timeout stays 0.
REQ-016 A new start is accepted on the first cycle back in IDLE (the cycle after done). Minimum frame period is 1 + 1 + 128 + WAIT cycles.
REQ-017 busy = 1 in START, SEND and WAIT; 0 in IDLE.

Reset
REQ-018 RST=1 asynchronously forces the state machine and all outputs:
- state IDLE;
- output_data=8'h00, data_start=0, busy=0;
- expected_sum=17'h0, done=0, pass=0, timeout=0;
- LFSR=8'h01, all counters 0.
REQ-019 RST asserted mid-frame aborts immediately; no done pulse follows. Operation resumes only on a fresh start after RST is released.

Verification
REQ-020 Constant max: const_mode=1, seed=8'hFF, start; summer model returns 17'h07F80 -> data_start one cycle, 128 bytes of FF, expected_sum=17'h07F80, pass=1, done pulse.
REQ-021 Mismatch: const_mode=1, seed=8'h01, sum_in=17'h00081 -> expected_sum=17'h00080, pass=0, timeout=0.
REQ-022 Timeout: any frame, sum_enable_in never asserted -> done and timeout=1 exactly 48 cycles after entering WAIT.
REQ-023 LFSR sequence: const_mode=0, seed=8'h00 -> first SEND bytes 01, 02, 04, 08; expected_sum equals the bench model's sum of the same sequence.
REQ-024 Protocol: start re-asserted during SEND is ignored; mid-SEND RST -> outputs at reset values the same cycle, no done.
REQ-025 Back-to-back: start held high -> second frame's data_start occurs the cycle after the first done; pass and timeout cleared at that start.
